// File: rtl/alu_seq_icc.sv
// SPARC-style ALU with a registered result, internal icc (N Z V C) and an
// iterative shift-add multiplier that writes the high product word to Y.
module alu_seq_icc #(
    parameter int         WIDTH   = 32,
    parameter logic [3:0] ICC_RST = 4'b0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       opcode,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] y_out,
    output logic             n,
    output logic             z,
    output logic             v,
    output logic             c,
    output logic             err
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [3:0] {
        OP_ADD, OP_AND, OP_OR, OP_XOR, OP_SUB, OP_ANDN, OP_ORN, OP_XNOR,
        OP_ADDX, OP_SUBX, OP_UMUL, OP_SMUL, OP_SLL, OP_SRL, OP_SRA, OP_ILL
    } op_e;

    typedef enum logic {
        ST_IDLE,
        ST_MUL
    } state_e;

    state_e           state;
    state_e           state_nxt;
    op_e              op;
    logic             upd_cc;
    logic             is_mul;
    logic             fire;
    logic             mul_done;
    logic [SHW-1:0]   shamt;
    logic             cin;
    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   sub_full;
    logic [WIDTH-1:0] alu_res;
    logic             alu_v;
    logic             alu_c;

    logic             signed_mul;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] plier;
    logic [WIDTH-1:0] acc_hi;
    logic             mul_neg;
    logic             mul_cc;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   step_sum;
    logic [2*WIDTH-1:0] prod_raw;
    logic [2*WIDTH-1:0] prod;

    // Opcode decode: index is {opcode[5], opcode[3:0]}, opcode[4] is S.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        op = OP_ILL;
        case ({opcode[5], opcode[3:0]})
            5'b0_0000: op = OP_ADD;
            5'b0_0001: op = OP_AND;
            5'b0_0010: op = OP_OR;
            5'b0_0011: op = OP_XOR;
            5'b0_0100: op = OP_SUB;
            5'b0_0101: op = OP_ANDN;
            5'b0_0110: op = OP_ORN;
            5'b0_0111: op = OP_XNOR;
            5'b0_1000: op = OP_ADDX;
            5'b0_1100: op = OP_SUBX;
            5'b0_1010: op = OP_UMUL;
            5'b0_1011: op = OP_SMUL;
            5'b1_0101: op = opcode[4] ? OP_ILL : OP_SLL;
            5'b1_0110: op = opcode[4] ? OP_ILL : OP_SRL;
            5'b1_0111: op = opcode[4] ? OP_ILL : OP_SRA;
            default:   op = OP_ILL;
        endcase
    end

    assign upd_cc     = opcode[4] && (op != OP_ILL);
    assign is_mul     = (op == OP_UMUL) || (op == OP_SMUL);
    assign signed_mul = (op == OP_SMUL);
    assign fire       = in_valid && in_ready;
    assign mul_done   = (state == ST_MUL) && (cnt == CNT_LAST);
    assign shamt      = b_in[SHW-1:0];

    // Single-cycle datapath; extended-width add/sub expose carry and borrow.
    always_comb begin
        cin      = ((op == OP_ADDX) || (op == OP_SUBX)) ? c : 1'b0;
        add_full = {1'b0, a_in} + {1'b0, b_in} + {{WIDTH{1'b0}}, cin};
        sub_full = {1'b0, a_in} - {1'b0, b_in} - {{WIDTH{1'b0}}, cin};
        alu_res  = '0;
        alu_v    = 1'b0;
        alu_c    = 1'b0;
        case (op)
            OP_ADD, OP_ADDX: begin
                alu_res = add_full[WIDTH-1:0];
                alu_c   = add_full[WIDTH];
                alu_v   = (a_in[WIDTH-1] == b_in[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != a_in[WIDTH-1]);
            end
            OP_SUB, OP_SUBX: begin
                alu_res = sub_full[WIDTH-1:0];
                alu_c   = sub_full[WIDTH];
                alu_v   = (a_in[WIDTH-1] != b_in[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != a_in[WIDTH-1]);
            end
            OP_AND:  alu_res = a_in & b_in;
            OP_OR:   alu_res = a_in | b_in;
            OP_XOR:  alu_res = a_in ^ b_in;
            OP_ANDN: alu_res = a_in & ~b_in;
            OP_ORN:  alu_res = a_in | ~b_in;
            OP_XNOR: alu_res = ~(a_in ^ b_in);
            OP_SLL:  alu_res = a_in << shamt;
            OP_SRL:  alu_res = a_in >> shamt;
            OP_SRA:  alu_res = $signed(a_in) >>> shamt;
            default: alu_res = '0;
        endcase
    end

    // smul works on magnitudes; the sign is applied to the full product at the end.
    always_comb begin
        mag_a = (signed_mul && a_in[WIDTH-1]) ? -a_in : a_in;
        mag_b = (signed_mul && b_in[WIDTH-1]) ? -b_in : b_in;
    end

    // One shift-add step: {acc_hi, plier} shifts right as multiplier bits retire.
    always_comb begin
        step_sum = {1'b0, acc_hi} + (plier[0] ? {1'b0, mcand} : '0);
        prod_raw = {step_sum, plier[WIDTH-1:1]};
        prod     = mul_neg ? -prod_raw : prod_raw;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid && is_mul) begin
                    state_nxt = ST_MUL;
                end
            end
            ST_MUL: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: reset is synchronous here, so every register is cleared inside the clocked branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            err          <= 1'b0;
            result       <= '0;
            y_out        <= '0;
            {n, z, v, c} <= ICC_RST;
            mcand        <= '0;
            plier        <= '0;
            acc_hi       <= '0;
            mul_neg      <= 1'b0;
            mul_cc       <= 1'b0;
            cnt          <= '0;
        end else begin
            out_valid <= 1'b0;
            err       <= 1'b0;

            if (fire) begin
                if (is_mul) begin
                    mcand   <= mag_a;
                    plier   <= mag_b;
                    acc_hi  <= '0;
                    mul_neg <= signed_mul && (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
                    mul_cc  <= opcode[4];
                    cnt     <= '0;
                end else begin
                    out_valid <= 1'b1;
                    err       <= (op == OP_ILL);
                    result    <= alu_res;
                    if (upd_cc) begin
                        {n, z, v, c} <= {alu_res[WIDTH-1], alu_res == '0, alu_v, alu_c};
                    end
                end
            end

            if (state == ST_MUL) begin
                acc_hi <= step_sum[WIDTH:1];
                plier  <= {step_sum[0], plier[WIDTH-1:1]};
                cnt    <= cnt + 1'b1;
                if (mul_done) begin
                    cnt       <= '0;
                    out_valid <= 1'b1;
                    result    <= prod[WIDTH-1:0];
                    y_out     <= prod[2*WIDTH-1:WIDTH];
                    if (mul_cc) begin
                        {n, z, v, c} <= {prod[WIDTH-1], prod[WIDTH-1:0] == '0, 1'b0, 1'b0};
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_seq_icc.sv
// Self-checking bench for alu_seq_icc: directed vector table, multi-cycle
// corner sequences, then random operations against a behavioural model.
module tb_alu_seq_icc;

    localparam int W = 32;
    localparam longint MAXI = 64'sd2147483647;
    localparam longint MINI = -64'sd2147483648;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [5:0]    opcode;
    logic [W-1:0]  a_in;
    logic [W-1:0]  b_in;
    logic          out_valid;
    logic [W-1:0]  result;
    logic [W-1:0]  y_out;
    logic          n, z, v, c;
    logic          err;

    int n_vec  = 0;
    int n_miss = 0;

    logic [3:0]   m_icc;
    logic [W-1:0] m_y;

    alu_seq_icc #(.WIDTH(W), .ICC_RST(4'b0000)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .result    (result),
        .y_out     (y_out),
        .n         (n),
        .z         (z),
        .v         (v),
        .c         (c),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [W-1:0] y;
        logic [3:0]   nzvc;
        logic         err;
        int           lat;
    } vec_t;

    vec_t tbl[20];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issue one op, wait (bounded) for its out_valid, and confirm the pulse is one cycle wide.
    task automatic issue(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic [W-1:0] y, output logic [3:0] f,
                         output logic e, output int lat, output int low_cnt);
        int waitc;
        waitc = 0;
        @(negedge clk);
        opcode   = op;
        a_in     = a;
        b_in     = b;
        in_valid = 1'b1;
        while (!in_ready && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat      = 0;
        low_cnt  = 0;
        while (!out_valid && lat < 100) begin
            if (!in_ready) low_cnt++;
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) check("out_valid_timeout", 0, 1);
        r = result;
        y = y_out;
        f = {n, z, v, c};
        e = err;
        @(posedge clk);
        #1;
        check("out_valid_pulse", out_valid, 0);
    endtask

    // Behavioural reference: plain integer arithmetic over the opcode table.
    task automatic model_op(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            output logic [W-1:0] r, output logic e, output int lat);
        longint     sa, sb, t;
        logic [63:0] p;
        logic       nv, nc, legal, cin;
        sa    = $signed(a);
        sb    = $signed(b);
        cin   = m_icc[0];
        nv    = 1'b0;
        nc    = 1'b0;
        legal = 1'b1;
        lat   = 0;
        r     = '0;
        case ({op[5], op[3:0]})
            5'b0_0000, 5'b0_1000: begin
                if (op[3] == 1'b0) cin = 1'b0;
                p  = longint'(a) + longint'(b) + longint'(cin);
                r  = p[31:0];
                nc = p[32];
                t  = sa + sb + longint'(cin);
                nv = (t > MAXI) || (t < MINI);
            end
            5'b0_0100, 5'b0_1100: begin
                if (op[3] == 1'b0) cin = 1'b0;
                r  = a - b - W'(cin);
                nc = longint'(a) < (longint'(b) + longint'(cin));
                t  = sa - sb - longint'(cin);
                nv = (t > MAXI) || (t < MINI);
            end
            5'b0_0001: r = a & b;
            5'b0_0010: r = a | b;
            5'b0_0011: r = a ^ b;
            5'b0_0101: r = a & ~b;
            5'b0_0110: r = a | ~b;
            5'b0_0111: r = ~(a ^ b);
            5'b0_1010, 5'b0_1011: begin
                if (op[0]) p = sa * sb;
                else       p = {32'b0, a} * {32'b0, b};
                r    = p[31:0];
                m_y  = p[63:32];
                lat  = W;
            end
            5'b1_0101: if (op[4]) legal = 1'b0; else r = a << b[4:0];
            5'b1_0110: if (op[4]) legal = 1'b0; else r = a >> b[4:0];
            5'b1_0111: if (op[4]) legal = 1'b0; else r = $signed(a) >>> b[4:0];
            default:   legal = 1'b0;
        endcase
        if (!legal) r = '0;
        e = !legal;
        if (legal && op[4]) m_icc = {r[31], r == 0, nv, nc};
    endtask

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    logic [5:0] legal_ops[15] = '{
        6'b000000, 6'b000001, 6'b000010, 6'b000011, 6'b000100, 6'b000101, 6'b000110,
        6'b000111, 6'b001000, 6'b001100, 6'b001010, 6'b001011, 6'b100101, 6'b100110,
        6'b100111
    };

    initial begin
        logic [W-1:0] r, y, ea, eb, er;
        logic [3:0]   f;
        logic         e, ee;
        int           lat, low, elat, pulses;
        logic [5:0]   op;

        tbl[0]  = '{6'b010000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h00000000, 4'b0101, 1'b0, 0};
        tbl[1]  = '{6'b001000, 32'h00000001, 32'h00000001, 32'h00000003, 32'h00000000, 4'b0101, 1'b0, 0};
        tbl[2]  = '{6'b010100, 32'h00000001, 32'h00000002, 32'hFFFFFFFF, 32'h00000000, 4'b1001, 1'b0, 0};
        tbl[3]  = '{6'b011100, 32'hEFFFFFFF, 32'hFFFFFFFF, 32'hEFFFFFFF, 32'h00000000, 4'b1001, 1'b0, 0};
        tbl[4]  = '{6'b011011, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFA, 32'hFFFFFFFF, 4'b1000, 1'b0, 32};
        tbl[5]  = '{6'b001010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 4'b1000, 1'b0, 32};
        tbl[6]  = '{6'b100111, 32'h80000000, 32'h00000004, 32'hF8000000, 32'hFFFFFFFE, 4'b1000, 1'b0, 0};
        tbl[7]  = '{6'b100101, 32'h00000001, 32'd33,       32'h00000002, 32'hFFFFFFFE, 4'b1000, 1'b0, 0};
        tbl[8]  = '{6'b100110, 32'h00000001, 32'h00000001, 32'h00000000, 32'hFFFFFFFE, 4'b1000, 1'b0, 0};
        tbl[9]  = '{6'b111111, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 32'hFFFFFFFE, 4'b1000, 1'b1, 0};
        tbl[10] = '{6'b010001, 32'h11110000, 32'h11111111, 32'h11110000, 32'hFFFFFFFE, 4'b0000, 1'b0, 0};
        tbl[11] = '{6'b010000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'hFFFFFFFE, 4'b1010, 1'b0, 0};
        tbl[12] = '{6'b010100, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'hFFFFFFFE, 4'b0010, 1'b0, 0};
        tbl[13] = '{6'b010011, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00000000, 32'hFFFFFFFE, 4'b0100, 1'b0, 0};
        tbl[14] = '{6'b011000, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFE, 4'b1000, 1'b0, 0};
        tbl[15] = '{6'b110101, 32'h00000001, 32'h00000001, 32'h00000000, 32'hFFFFFFFE, 4'b1000, 1'b1, 0};
        tbl[16] = '{6'b001011, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 4'b1000, 1'b0, 32};
        tbl[17] = '{6'b010110, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h40000000, 4'b0100, 1'b0, 0};
        tbl[18] = '{6'b010101, 32'hFFFFFFFF, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'h40000000, 4'b1000, 1'b0, 0};
        tbl[19] = '{6'b010111, 32'h12345678, 32'h12345678, 32'hFFFFFFFF, 32'h40000000, 4'b1000, 1'b0, 0};

        rst      = 1'b1;
        in_valid = 1'b0;
        opcode   = '0;
        a_in     = '0;
        b_in     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result",    result, 0);
        check("rst_y",         y_out, 0);
        check("rst_nzvc",      {n, z, v, c}, 4'b0000);
        check("rst_err",       err, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            issue(tbl[i].op, tbl[i].a, tbl[i].b, r, y, f, e, lat, low);
            check($sformatf("tbl%0d_result", i), r, tbl[i].res);
            check($sformatf("tbl%0d_y", i),      y, tbl[i].y);
            check($sformatf("tbl%0d_nzvc", i),   f, tbl[i].nzvc);
            check($sformatf("tbl%0d_err", i),    e, tbl[i].err);
            check($sformatf("tbl%0d_latency", i), lat, tbl[i].lat);
            check($sformatf("tbl%0d_ready_low", i), low, tbl[i].lat);
        end

        // Back-to-back: the second op must see the carry produced one edge earlier.
        @(negedge clk);
        opcode = 6'b010000; a_in = 32'hFFFFFFFF; b_in = 32'h1; in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("b2b_first_valid",  out_valid, 1);
        check("b2b_first_nzvc",   {n, z, v, c}, 4'b0101);
        check("b2b_ready",        in_ready, 1);
        opcode = 6'b011000; a_in = 32'hFFFFFFFE; b_in = 32'h0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("b2b_second_valid",  out_valid, 1);
        check("b2b_second_result", result, 32'hFFFFFFFF);
        check("b2b_second_nzvc",   {n, z, v, c}, 4'b1000);
        @(posedge clk);
        #1;
        check("b2b_idle_valid", out_valid, 0);

        // Reset ten cycles into a multiply aborts it with no late out_valid.
        @(negedge clk);
        opcode = 6'b011011; a_in = 32'hFFFFFFFE; b_in = 32'h3; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mrst_in_ready",  in_ready, 1);
        check("mrst_out_valid", out_valid, 0);
        check("mrst_nzvc",      {n, z, v, c}, 4'b0000);
        check("mrst_y",         y_out, 0);
        @(negedge clk);
        rst    = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) pulses++;
        end
        check("mrst_no_late_valid", pulses, 0);

        m_icc = 4'b0000;
        m_y   = '0;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                op = 6'($urandom_range(0, 63));
            end else begin
                op = legal_ops[$urandom_range(0, 14)];
                if (!op[5]) op[4] = 1'($urandom_range(0, 1));
            end
            ea = rand_operand();
            eb = rand_operand();
            issue(op, ea, eb, r, y, f, e, lat, low);
            model_op(op, ea, eb, er, ee, elat);
            check($sformatf("rnd%0d_op%b_result", i, op), r, er);
            check($sformatf("rnd%0d_op%b_y", i, op),      y, m_y);
            check($sformatf("rnd%0d_op%b_nzvc", i, op),   f, m_icc);
            check($sformatf("rnd%0d_op%b_err", i, op),    e, ee);
            check($sformatf("rnd%0d_op%b_latency", i, op), lat, elat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/alu_seq_icc.md
Name: alu_seq_icc

Overview:
- Pipelined, parametrised-width successor to the combinational 32-bit SPARC-style ALU.
- Accepts one operation per valid/ready handshake and returns a registered result.
- Holds the integer condition codes (icc: N Z V C) internally. They update only on cc-variant opcodes, and addx/subx read the stored C.
- Adds iterative unsigned/signed multiply with a Y high-word register. Sits between register-file read and writeback in the integer pipeline.

Parameters:
- WIDTH, 32, datapath width. Power of two, at least 8. SHW = log2(WIDTH) is derived internally.
- ICC_RST, 4'b0000, icc value {N,Z,V,C} loaded on reset.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  block can accept. Handshake fires when in_valid && in_ready at a rising edge.
- opcode  in  6  operation select (encoding below).
- a_in  in  WIDTH  operand A.
- b_in  in  WIDTH  operand B.
- out_valid  out  1  result/flags valid; single-cycle pulse.
- result  out  WIDTH  registered result.
- y_out  out  WIDTH  Y register (high product word).
- n, z, v, c  out  1 each  registered icc bits.
- err  out  1  illegal opcode; pulses with out_valid.

Behaviour:
- Reset values: in_ready=1, out_valid=0, result=0, y_out=0, {n,z,v,c}=ICC_RST, err=0. Reset mid-multiply aborts the operation; no out_valid follows it.
- Opcode bit4 = S (update icc). Low bits {5,3:0}:
  - 0_0000 add
  - 0_0001 and
  - 0_0010 or
  - 0_0011 xor
  - 0_0100 sub
  - 0_0101 andn (A & ~B)
  - 0_0110 orn
  - 0_0111 xnor
  - 0_1000 addx (A+B+C)
  - 0_1100 subx (A-B-C)
  - 0_1010 umul
  - 0_1011 smul
  - 1_0101 sll
  - 1_0110 srl
  - 1_0111 sra
  - Shifts are legal only with S=0.
  - All other codes are illegal.
- Single-cycle ops:
  - Accepted at edge k.
  - result, icc and err registered at edge k.
  - out_valid high for the cycle after k. in_ready stays 1, so back-to-back issue is allowed.
  - The next op (edge k+1) sees the updated icc.
- addx/subx use the registered c at the accept edge.
- Shift amount = b_in[SHW-1:0]; upper bits are ignored. sra replicates a_in[WIDTH-1].
- Flags, when S=1:
  - N = result[WIDTH-1]; Z = (result==0).
  - add/addx: C = carry-out. V = operand signs equal and result sign differs.
  - sub/subx: C = borrow (A < B+Cin, unsigned). V = operand signs differ and result sign differs from A.
  - Logic ops: V=C=0.
  - Multiplies: N and Z from the low word; V=C=0.
- With S=0, icc holds.
- Multiply:
  - Accept at edge k latches the operands and enters state MUL. in_ready drops to 0 from the cycle after k.
  - Shift-add runs one bit per edge for WIDTH edges, k+1..k+WIDTH.
  - The 2*WIDTH product is registered at edge k+WIDTH: low word to result, high word to y_out. icc is updated if S=1.
  - out_valid is high and in_ready high in the cycle after k+WIDTH.
  - smul takes operand magnitudes and negates the 2*WIDTH product when the signs differ.
  - y_out changes only on multiply completion.
- State machine: IDLE -> (mul accepted) MUL -> (counter==WIDTH-1) IDLE. A counter of SHW+1 bits wraps cleanly with no residue.
- Illegal opcode: result=0, err=1 and out_valid=1 for one cycle. icc and y unchanged.
- in_valid while in_ready=0 is ignored. The source must hold its operation.

Test Plan (WIDTH=32):
1. addcc (010000) A=FFFFFFFF, B=00000001 -> result 00000000, out_valid the next cycle, nzvc=0101. Then addx (001000) A=1, B=1 -> result 00000003, nzvc still 0101.
2. subcc (010100) A=1, B=2 -> FFFFFFFF, nzvc=1001. Then subxcc (011100) A=EFFFFFFF, B=FFFFFFFF with C=1 -> EFFFFFFF, nzvc=1001.
3. smulcc (011011) A=FFFFFFFE, B=00000003:
   - in_ready low for 32 cycles.
   - out_valid exactly 32 cycles after the accept cycle.
   - result FFFFFFFA, y_out FFFFFFFF, nzvc=1000.
   - umul (001010) FFFFFFFF*FFFFFFFF -> result 00000001, y FFFFFFFE, icc unchanged.
4. sra (100111) A=80000000, B=4 -> F8000000. sll (100101) A=1, B=33 -> 00000002. srl (100110) A=1, B=1 -> 0. icc unchanged throughout.
5. rst asserted 10 cycles into smul -> next cycle: in_ready=1, out_valid=0, nzvc=0000, y_out=0. No late out_valid.
6. Illegal opcode 111111 -> out_valid=1, err=1, result 0, icc unchanged. Then andcc (010001) A=11110000, B=11111111 -> 11110000, err=0, nzvc=0000.
